// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: instruction codes,
// state encoding, default latencies and instruction classification helpers.
package muldiv_ctrl_pkg;

  localparam logic [7:0] INST_MULT  = 8'h18;
  localparam logic [7:0] INST_MULTU = 8'h19;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;
  localparam logic [7:0] INST_MADD  = 8'hA6;
  localparam logic [7:0] INST_MADDU = 8'hA7;
  localparam logic [7:0] INST_MSUB  = 8'hA8;
  localparam logic [7:0] INST_MSUBU = 8'hA9;

  localparam int MUL_CYCLES_DEFAULT = 2;
  localparam int DIV_ITER_DEFAULT   = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_supported(input logic [7:0] code);
    logic ok;
    case (code)
      INST_MULT, INST_MULTU, INST_DIV, INST_DIVU,
      INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_signed_op(input logic [7:0] code);
    return (code == INST_MULT) || (code == INST_DIV) ||
           (code == INST_MADD) || (code == INST_MSUB);
  endfunction

  function automatic logic is_div_op(input logic [7:0] code);
    return (code == INST_DIV) || (code == INST_DIVU);
  endfunction

  function automatic logic is_acc_op(input logic [7:0] code);
    return (code == INST_MADD) || (code == INST_MADDU) ||
           (code == INST_MSUB) || (code == INST_MSUBU);
  endfunction

  function automatic logic is_sub_op(input logic [7:0] code);
    return (code == INST_MSUB) || (code == INST_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Unsigned restoring divider, one quotient bit per clock. q/r present the values
// after the step being taken this cycle, so the caller can capture the final step.
module div_radix2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [32:0] shifted;

  always_comb begin
    shifted = {rem_r, quo_r[31]};
    if (shifted >= {1'b0, dvs_r}) begin
      r = 32'(shifted - {1'b0, dvs_r});
      q = {quo_r[30:0], 1'b1};
    end else begin
      r = shifted[31:0];
      q = {quo_r[30:0], 1'b0};
    end
  end

  // Free-running once loaded; the sequencer only samples q/r on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
    end else if (clear) begin
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
    end else if (start) begin
      rem_r <= '0;
      quo_r <= dividend;
      dvs_r <= divisor;
    end else begin
      rem_r <= r;
      quo_r <= q;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: runs MULT/MADD/MSUB through a multiplier pipeline or
// DIV through the serial divider, stalls EX, and issues a one-shot HI/LO write.
//
// state | meaning
// IDLE  | waiting for a supported multi-cycle instruction
// MUL   | multiplier pipeline filling, counter running down
// ACC   | combine product with forwarded HI/LO (MADD*/MSUB*)
// DIV   | one restoring divide step per cycle
// DONE  | result valid, write HI/LO once hold_i is low
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_ITER   = DIV_ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  inst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [63:0] hilo_i,
  input  logic        exception_flush,
  input  logic        hold_i,
  output logic        stall_o,
  output logic        busy,
  output logic [63:0] result,
  output logic        hilo_we
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITER) ? MUL_CYCLES : DIV_ITER;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    inst_r;
  logic          sgn_r;
  logic          s1_r;
  logic          s2_r;

  logic          op_signed;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic          accept;
  logic [63:0]   pipe [MUL_CYCLES];
  logic [63:0]   prod_fix;
  logic [31:0]   div_q;
  logic [31:0]   div_r;
  logic [31:0]   q_fix;
  logic [31:0]   r_fix;

  assign op_signed = is_signed_op(inst);
  assign abs_a     = (op_signed && op1[31]) ? -op1 : op1;
  assign abs_b     = (op_signed && op2[31]) ? -op2 : op2;
  assign accept    = (state == ST_IDLE) && req && is_supported(inst) && !exception_flush;

  assign busy    = (state != ST_IDLE);
  assign hilo_we = (state == ST_DONE) && !hold_i && !exception_flush;
  assign stall_o = req && is_supported(inst) && !((state == ST_DONE) && !hold_i);

  // Magnitude product enters at the accepting edge and emerges MUL_CYCLES-1 edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_CYCLES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= 64'(abs_a) * 64'(abs_b);
      for (int i = 1; i < MUL_CYCLES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign prod_fix = (sgn_r && (s1_r ^ s2_r)) ? -pipe[MUL_CYCLES-1] : pipe[MUL_CYCLES-1];
  assign q_fix    = (sgn_r && (s1_r ^ s2_r)) ? -div_q : div_q;
  assign r_fix    = (sgn_r && s1_r) ? -div_r : div_r;

  div_radix2 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && is_div_op(inst)),
    .clear    (exception_flush),
    .dividend (abs_a),
    .divisor  (abs_b),
    .q        (div_q),
    .r        (div_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      inst_r <= '0;
      sgn_r  <= 1'b0;
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      result <= '0;
    end else if (exception_flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            inst_r <= inst;
            sgn_r  <= op_signed;
            s1_r   <= op1[31];
            s2_r   <= op2[31];
            if (is_div_op(inst)) begin
              state <= ST_DIV;
              cnt   <= CW'(DIV_ITER);
            end else begin
              state <= ST_MUL;
              cnt   <= CW'(MUL_CYCLES);
            end
          end
        end
        ST_MUL: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= prod_fix;
            state  <= is_acc_op(inst_r) ? ST_ACC : ST_DONE;
          end
        end
        ST_ACC: begin
          result <= is_sub_op(inst_r) ? (hilo_i - result) : (hilo_i + result);
          state  <= ST_DONE;
        end
        ST_DIV: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= {r_fix, q_fix};
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!hold_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
